// File: rtl/a2d_pkg.sv
// Shared types and constants for the load-cell A2D round-robin reader.
// Holds FSM encodings, default ADC channel map, SPI divider phases and the command-word helper.
package a2d_pkg;

    typedef enum logic [1:0] {IDLE, CMD, GAP, READ} a2d_state_t;
    typedef enum logic [1:0] {SPI_IDLE, SPI_FRONT, SPI_XFER} spi_state_t;

    localparam logic [2:0] DFLT_LFT_CH   = 3'd0;
    localparam logic [2:0] DFLT_RGHT_CH  = 3'd4;
    localparam logic [2:0] DFLT_STEER_CH = 3'd5;
    localparam logic [2:0] DFLT_BATT_CH  = 3'd6;

    localparam logic [4:0] DIV_LOAD = 5'b10111;
    localparam logic [4:0] DIV_SMPL = 5'b01111;
    localparam logic [4:0] DIV_SHFT = 5'b11111;

    function automatic logic [15:0] cmd_word(input logic [2:0] chnl);
        return {2'b00, chnl, 11'h000};
    endfunction

endpackage

// File: rtl/spi_mnrch.sv
// 16-bit SPI master, SCLK = clk/32, MOSI launched on SCLK fall, MISO sampled just before SCLK rise.
// done (and rd_data) valid for one clk 520 clks after wrt; wrt is ignored while a frame is in flight.
module spi_mnrch
    import a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    spi_state_t  state, nxt_state;
    logic [4:0]  div;
    logic [3:0]  bit_cnt;
    logic [15:0] shft_reg;
    logic        miso_smpl;
    logic        ss_q;
    logic        smpl, shft, last;

    always_comb begin
        smpl = (state != SPI_IDLE) && (div == DIV_SMPL);
        shft = (state == SPI_XFER) && (div == DIV_SHFT);
        last = shft && (bit_cnt == 4'd15);
    end

    always_comb begin
        nxt_state = state;
        case (state)
            SPI_IDLE:  if (wrt)  nxt_state = SPI_FRONT;
            SPI_FRONT: if (smpl) nxt_state = SPI_XFER;
            SPI_XFER:  if (last) nxt_state = SPI_IDLE;
            default:             nxt_state = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SPI_IDLE;
        else        state <= nxt_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= DIV_LOAD;
            bit_cnt   <= 4'd0;
            shft_reg  <= 16'h0000;
            miso_smpl <= 1'b0;
            ss_q      <= 1'b1;
        end else if (state == SPI_IDLE) begin
            if (wrt) begin
                ss_q     <= 1'b0;
                shft_reg <= wt_data;
                div      <= DIV_LOAD;
                bit_cnt  <= 4'd0;
            end
        end else begin
            // Reloading on the last shift parks SCLK high so no 17th falling edge appears.
            div <= last ? DIV_LOAD : div + 5'd1;
            if (smpl) miso_smpl <= MISO;
            if (shft) begin
                shft_reg <= {shft_reg[14:0], miso_smpl};
                bit_cnt  <= bit_cnt + 4'd1;
            end
            if (last) ss_q <= 1'b1;
        end
    end

    // Chip select lifts during the done clk too, giving the caller a 2-clk deselect gap.
    assign done    = last;
    assign rd_data = last ? {shft_reg[14:0], miso_smpl} : shft_reg;
    assign SS_n    = ss_q | last;
    assign SCLK    = div[4];
    assign MOSI    = shft_reg[15];

endmodule

// File: rtl/load_cell_a2d_intf.sv
// Round-robin ADC reader: each nxt runs two SPI frames and updates one result 1043 clks later.
// nxt is dropped unless idle; vld pulses once per full round when batt is written.
module load_cell_a2d_intf
    import a2d_pkg::*;
#(
    parameter logic [2:0] LFT_CH   = DFLT_LFT_CH,
    parameter logic [2:0] RGHT_CH  = DFLT_RGHT_CH,
    parameter logic [2:0] STEER_CH = DFLT_STEER_CH,
    parameter logic [2:0] BATT_CH  = DFLT_BATT_CH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        vld
);

    a2d_state_t  state, nxt_state;
    logic [1:0]  rr;
    logic [2:0]  chnl;
    logic        wrt, done, capture;
    logic [15:0] rd_data;
    logic [3:0]  rd_pad_unused;
    logic [11:0] rd_res;

    assign {rd_pad_unused, rd_res} = rd_data;

    always_comb begin
        case (rr)
            2'd0:    chnl = LFT_CH;
            2'd1:    chnl = RGHT_CH;
            2'd2:    chnl = STEER_CH;
            default: chnl = BATT_CH;
        endcase
    end

    // Frame 2 repeats the same command; its read-back carries frame 1's conversion.
    always_comb begin
        nxt_state = state;
        wrt       = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: if (nxt) begin
                wrt       = 1'b1;
                nxt_state = CMD;
            end
            CMD:  if (done) nxt_state = GAP;
            GAP: begin
                wrt       = 1'b1;
                nxt_state = READ;
            end
            READ: if (done) begin
                capture   = 1'b1;
                nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr        <= 2'd0;
            vld       <= 1'b0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
        end else begin
            vld <= capture && (rr == 2'd3);
            if (capture) begin
                case (rr)
                    2'd0:    lft_ld    <= rd_res;
                    2'd1:    rght_ld   <= rd_res;
                    2'd2:    steer_pot <= rd_res;
                    default: batt      <= rd_res;
                endcase
                rr <= rr + 2'd1;
            end
        end
    end

    spi_mnrch u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .wt_data (cmd_word(chnl)),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

endmodule

// File: tb/tb_load_cell_a2d_intf.sv
// Directed bench for load_cell_a2d_intf with a pipelined ADC model and an expectation queue.
module tb_load_cell_a2d_intf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nxt;
    logic        MISO = 1'b0;
    logic        SS_n, SCLK, MOSI, vld;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;

    load_cell_a2d_intf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .MISO      (MISO),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .vld       (vld)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: frame n selects a channel, frame n+1 shifts that channel's data out MSB first.
    logic [11:0] adc_data [8];
    logic [15:0] adc_tx = 16'h0000;
    logic [15:0] adc_rx = 16'h0000;
    int          adc_nbit = 0;
    logic [2:0]  adc_ch = 3'd0;
    logic [15:0] cmd_q [$];

    always @(negedge SS_n) begin
        adc_tx   <= {4'h0, adc_data[adc_ch]};
        adc_nbit <= 0;
    end
    always @(negedge SCLK) if (!SS_n) begin
        MISO   <= adc_tx[15];
        adc_tx <= {adc_tx[14:0], 1'b0};
    end
    always @(posedge SCLK) if (!SS_n) begin
        adc_rx   <= {adc_rx[14:0], MOSI};
        adc_nbit <= adc_nbit + 1;
    end
    always @(posedge SS_n) if (adc_nbit == 16) begin
        cmd_q.push_back(adc_rx);
        adc_ch <= adc_rx[13:11];
    end

    // SPI waveform monitor, sampled on the falling clk edge.
    logic p_ss = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0;
    int   rises = 0, falls = 0, last_fall = -1;
    int   frames = 0, frame_bad = 0, per_bad = 0, mosi_bad = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (p_ss && !SS_n) begin
                rises     <= 0;
                falls     <= 0;
                last_fall <= -1;
            end else begin
                if (!p_sclk && SCLK) begin
                    rises <= rises + 1;
                    if (MOSI !== p_mosi) mosi_bad <= mosi_bad + 1;
                end
                if (p_sclk && !SCLK) begin
                    falls <= falls + 1;
                    if (last_fall >= 0 && cyc - last_fall != 32) per_bad <= per_bad + 1;
                    last_fall <= cyc;
                end
            end
            if (!p_ss && SS_n) begin
                frames <= frames + 1;
                if (rises != 16 || falls != 16) frame_bad <= frame_bad + 1;
            end
        end
        p_ss   <= SS_n;
        p_sclk <= SCLK;
        p_mosi <= MOSI;
    end

    typedef struct {
        int          sel;
        logic [11:0] val;
        logic [15:0] cmd;
        logic        v;
    } exp_t;

    exp_t        sb [$];
    logic [11:0] exp_regs [4];
    logic [2:0]  ch_tab [4];
    int          tb_rr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] get_reg(input int s);
        case (s)
            0:       return lft_ld;
            1:       return rght_ld;
            2:       return steer_pot;
            default: return batt;
        endcase
    endfunction

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_reg%0d", tag, i), 32'(get_reg(i)), 32'(exp_regs[i]));
    endtask

    task automatic run_conv(input bit busy);
        exp_t e, g;
        e.sel = tb_rr;
        e.val = adc_data[ch_tab[tb_rr]];
        e.cmd = {2'b00, ch_tab[tb_rr], 11'h000};
        e.v   = (tb_rr == 3);
        sb.push_back(e);
        @(negedge clk) nxt = 1'b1;
        @(posedge clk);
        #1 nxt = 1'b0;
        chk("ss_low_start", 32'(SS_n), 32'd0);
        for (int k = 1; k <= 1044; k++) begin
            @(posedge clk);
            #1;
            nxt = busy && (k == 99 || k == 599);
            if (k == 519) chk("ss_before_done", 32'(SS_n), 32'd0);
            if (k == 520) chk("ss_at_done", 32'(SS_n), 32'd1);
            if (k == 521) chk("ss_gap", 32'(SS_n), 32'd1);
            if (k == 522) chk("ss_frame2", 32'(SS_n), 32'd0);
            if (k == 1042) check_all_regs("early");
            if (k == 1043) begin
                chk("sb_depth", 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    g = sb.pop_front();
                    exp_regs[g.sel] = g.val;
                    check_all_regs("result");
                    chk("vld_pulse", 32'(vld), 32'(g.v));
                end
            end
            if (k == 1044) begin
                chk("vld_clear", 32'(vld), 32'd0);
                chk("ss_idle_after", 32'(SS_n), 32'd1);
            end
        end
        chk("frame_count", 32'(cmd_q.size()), 32'd2);
        for (int f = 0; f < 2; f++)
            if (cmd_q.size() > 0) chk($sformatf("cmd_f%0d", f + 1), 32'(cmd_q.pop_front()), 32'(e.cmd));
        cmd_q.delete();
        tb_rr = (tb_rr + 1) % 4;
    endtask

    task automatic run_reset_mid_frame();
        exp_t e;
        e.sel = tb_rr;
        e.val = adc_data[ch_tab[tb_rr]];
        e.cmd = {2'b00, ch_tab[tb_rr], 11'h000};
        e.v   = (tb_rr == 3);
        sb.push_back(e);
        @(negedge clk) nxt = 1'b1;
        @(posedge clk);
        #1 nxt = 1'b0;
        repeat (822) @(posedge clk);
        #1;
        chk("mid_ss_low", 32'(SS_n), 32'd0);
        chk("mid_sclk_low", 32'(SCLK), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_ss_high", 32'(SS_n), 32'd1);
        chk("rst_sclk_high", 32'(SCLK), 32'd1);
        chk("rst_vld", 32'(vld), 32'd0);
        sb.delete();
        for (int i = 0; i < 4; i++) exp_regs[i] = 12'h000;
        check_all_regs("rst");
        chk("rst_frames", 32'(cmd_q.size()), 32'd1);
        if (cmd_q.size() > 0) chk("rst_cmd_f1", 32'(cmd_q.pop_front()), 32'(e.cmd));
        cmd_q.delete();
        tb_rr = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        nxt   = 1'b0;
        tb_rr = 0;
        ch_tab[0] = 3'd0;
        ch_tab[1] = 3'd4;
        ch_tab[2] = 3'd5;
        ch_tab[3] = 3'd6;
        for (int i = 0; i < 8; i++) adc_data[i] = 12'h000;
        for (int i = 0; i < 4; i++) exp_regs[i] = 12'h000;

        repeat (3) @(negedge clk);
        chk("reset_ss", 32'(SS_n), 32'd1);
        chk("reset_sclk", 32'(SCLK), 32'd1);
        chk("reset_mosi", 32'(MOSI), 32'd0);
        chk("reset_vld", 32'(vld), 32'd0);
        check_all_regs("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single conversion of the left load cell.
        adc_data[0] = 12'hA5C;
        run_conv(1'b0);

        // Reset in the middle of the right-load-cell read frame.
        adc_data[4] = 12'h7E1;
        run_reset_mid_frame();

        // Full round, with dropped nxt pulses during the second conversion.
        adc_data[0] = 12'h111;
        adc_data[4] = 12'h222;
        adc_data[5] = 12'h333;
        adc_data[6] = 12'h444;
        run_conv(1'b0);
        run_conv(1'b1);
        run_conv(1'b0);
        run_conv(1'b0);

        // Fifth nxt wraps back to the left load cell.
        adc_data[0] = 12'h5A5;
        run_conv(1'b0);

        repeat (4) @(negedge clk);
        chk("spi_frames_seen", 32'(frames), 32'd13);
        chk("spi_edge_counts", 32'(frame_bad), 32'd0);
        chk("spi_sclk_period", 32'(per_bad), 32'd0);
        chk("spi_mosi_on_rise", 32'(mosi_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
